// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 CTR engine.
package aes_pkg;

    localparam int AES_KEY_W         = 128;
    localparam int CTR_WIDTH_DEFAULT = 32;

    typedef logic [127:0] block_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctr_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (b^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = b;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 10; i++) begin
            if (i < n) r = xtime(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_128.sv
// Fully combinational AES-128 block encryption with on-the-fly key expansion.
module aes_128
    import aes_pkg::*;
(
    input  logic [127:0] in_bus,
    input  logic [127:0] key,
    output logic [127:0] out_bus
);

    function automatic block_t sub_shift(input block_t s);
        block_t r;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(4*c+w) -: 8] = sbox(s[127-8*(4*((c+w)%4)+w) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic block_t mix_cols(input block_t s);
        block_t     r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic block_t key_next(input block_t k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        t  = t ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    for (genvar r = 1; r <= 10; r++) begin : g_rnd
        block_t w_kin;
        block_t w_sin;
        block_t w_rk;
        block_t w_ss;
        block_t w_st;
        if (r == 1) begin : g_first
            assign w_kin = key;
            assign w_sin = in_bus ^ key;
        end else begin : g_next
            assign w_kin = g_rnd[r-1].w_rk;
            assign w_sin = g_rnd[r-1].w_st;
        end
        assign w_rk = key_next(w_kin, rcon(r - 1));
        assign w_ss = sub_shift(w_sin);
        if (r < 10) begin : g_mix
            assign w_st = mix_cols(w_ss) ^ w_rk;
        end else begin : g_final
            assign w_st = w_ss ^ w_rk;
        end
    end

    assign out_bus = g_rnd[10].w_st;

endmodule

// File: rtl/aes_ctr.sv
// AES-128 counter-mode streaming engine: one block per cycle, output-registered,
// valid/ready handshakes on config, input and output.
module aes_ctr
    import aes_pkg::*;
#(
    parameter int CTR_WIDTH = CTR_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [AES_KEY_W-1:0] cfg_key,
    input  logic [127:0]         cfg_iv,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 ctr_wrap
);

    // Selects the counter field; CTR_WIDTH=128 yields an all-ones mask.
    localparam block_t CTR_MASK = (block_t'(1) << CTR_WIDTH) - block_t'(1);

    ctr_state_e r_state;
    ctr_state_e w_state_nxt;
    block_t     r_key;
    block_t     r_ctr;
    block_t     r_out_data;
    logic       r_out_valid;
    logic       r_out_last;
    logic       r_wrap;

    logic       w_cfg_acc;
    logic       w_in_acc;
    logic       w_ctr_max;
    block_t     w_ctr_inc;
    block_t     w_ks;

    aes_128 u_aes (
        .in_bus  (r_ctr),
        .key     (r_key),
        .out_bus (w_ks)
    );

    assign cfg_ready = (r_state == IDLE) && !r_out_valid;
    assign in_ready  = (r_state == RUN) && (!r_out_valid || out_ready);
    assign w_cfg_acc = cfg_valid && cfg_ready;
    assign w_in_acc  = in_valid && in_ready;

    assign w_ctr_max = (r_ctr & CTR_MASK) == CTR_MASK;
    assign w_ctr_inc = (r_ctr & ~CTR_MASK) | ((r_ctr + block_t'(1)) & CTR_MASK);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_cfg_acc) w_state_nxt = RUN;
            RUN:     if (w_in_acc && in_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key  <= '0;
            r_ctr  <= '0;
            r_wrap <= 1'b0;
        end else if (w_cfg_acc) begin
            r_key  <= cfg_key;
            r_ctr  <= cfg_iv;
            r_wrap <= 1'b0;
        end else if (w_in_acc) begin
            r_ctr <= w_ctr_inc;
            if (w_ctr_max) r_wrap <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_in_acc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data ^ w_ks;
            r_out_last  <= in_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign ctr_wrap  = r_wrap;
    assign busy      = (r_state == RUN) || r_out_valid;

endmodule

// File: tb/tb_aes_ctr.sv
// Self-checking bench for aes_ctr: standard vectors, corner sequences, random traffic.
module tb_aes_ctr;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [127:0] cfg_key;
    logic [127:0] cfg_iv;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         busy;
    logic         ctr_wrap;

    always #5 clk = ~clk;

    aes_ctr #(.CTR_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_key   (cfg_key),
        .cfg_iv    (cfg_iv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .ctr_wrap  (ctr_wrap)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [256];

    bit           m_run, m_ov, m_ol, m_wrap, m_acc;
    logic [127:0] m_od, m_key, m_ctr;

    typedef struct {
        bit           cfg;
        logic [127:0] key;
        logic [127:0] iv;
        logic [127:0] din;
        bit           last;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [3];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Byte-array FIPS-197 reference using a table built by the generator walk.
    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rn = 1; rn <= 10; rn++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = sb[s[4*((c+r)%4)+r]];
            if (rn < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rn+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_ov = 0; m_ol = 0; m_wrap = 0; m_acc = 0;
        m_od = '0; m_key = '0; m_ctr = '0;
    endtask

    task automatic check_comb();
        chk("cfg_ready", cfg_ready, !m_run && !m_ov);
        chk("in_ready", in_ready, m_run && (!m_ov || out_ready));
        chk("busy", busy, m_run || m_ov);
    endtask

    task automatic check_regs();
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_last", out_last, m_ol);
        chk("ctr_wrap", ctr_wrap, m_wrap);
    endtask

    // Called at posedge+1 with inputs driven; returns at the following posedge+1.
    task automatic cycle();
        bit cacc, iacc;
        #1;
        check_comb();
        cacc = cfg_valid && !m_run && !m_ov;
        iacc = in_valid && m_run && (!m_ov || out_ready);
        @(posedge clk);
        #1;
        m_acc = iacc;
        if (cacc) begin
            m_key = cfg_key; m_ctr = cfg_iv; m_wrap = 0; m_run = 1;
        end
        if (iacc) begin
            m_od = in_data ^ ref_aes(m_ctr, m_key);
            m_ol = in_last;
            m_ov = 1;
            if (m_ctr[31:0] == 32'hffff_ffff) m_wrap = 1;
            m_ctr = {m_ctr[127:32], m_ctr[31:0] + 32'd1};
            if (in_last) m_run = 0;
        end else if (out_ready) begin
            m_ov = 0;
        end
        check_regs();
    endtask

    task automatic load(input logic [127:0] k, input logic [127:0] iv);
        bit done = 0;
        int n = 0;
        cfg_valid = 1; cfg_key = k; cfg_iv = iv;
        while (!done && n < 20) begin
            done = !m_run && !m_ov;
            cycle();
            n++;
        end
        cfg_valid = 0;
        chk("cfg_load_in_time", done, 1'b1);
    endtask

    task automatic send(input logic [127:0] d, input bit last);
        int n = 0;
        in_valid = 1; in_data = d; in_last = last;
        m_acc = 0;
        while (!m_acc && n < 20) begin
            cycle();
            n++;
        end
        in_valid = 0; in_last = 0;
        chk("send_in_time", m_acc, 1'b1);
    endtask

    task automatic drain();
        in_valid = 0; out_ready = 1;
        repeat (2) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, iv, hold, d1, d2;
        int           nacc;

        build_sbox();
        rst_n = 0; cfg_valid = 0; cfg_key = '0; cfg_iv = '0;
        in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
        m_reset();
        #12;
        check_comb();
        check_regs();
        rst_n = 1;
        @(posedge clk); #1;
        chk("rst_cfg_ready", cfg_ready, 1'b1);

        vt[0] = '{1, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h00112233445566778899aabbccddeeff, 128'h0, 1,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vt[1] = '{1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff,
                  128'h6bc1bee22e409f96e93d7e117393172a, 0,
                  128'h874d6191b620e3261bef6864990db6ce};
        vt[2] = '{0, 128'h0, 128'h0,
                  128'hae2d8a571e03ac9c9eb76fac45af8e51, 1,
                  128'h9806f66b7970fdff8617187bb9fffdff};
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            if (vt[i].cfg) load(vt[i].key, vt[i].iv);
            send(vt[i].din, vt[i].last);
            chk($sformatf("vec%0d_data", i), out_data, vt[i].exp);
            chk($sformatf("vec%0d_last", i), out_last, vt[i].last);
            if (vt[i].last) begin
                drain();
                chk($sformatf("vec%0d_idle", i), cfg_ready, 1'b1);
            end
        end

        k = rnd128();
        iv = {96'hc0ffee00_12345678_9abcdef0, 32'hffff_ffff};
        d1 = rnd128(); d2 = rnd128();
        load(k, iv);
        send(d1, 0);
        chk("wrap_blk1", out_data, d1 ^ ref_aes(iv, k));
        chk("wrap_set", ctr_wrap, 1'b1);
        send(d2, 1);
        chk("wrap_blk2", out_data, d2 ^ ref_aes({iv[127:32], 32'h0}, k));
        drain();
        chk("wrap_sticky", ctr_wrap, 1'b1);
        load(rnd128(), rnd128());
        chk("wrap_cleared", ctr_wrap, 1'b0);
        send(rnd128(), 1);
        drain();

        k = rnd128();
        iv = {rnd128() >> 32, 32'h0000_0010};
        load(k, iv);
        out_ready = 1;
        send(rnd128(), 0);
        out_ready = 0;
        d1 = rnd128();
        in_valid = 1; in_data = d1; in_last = 0;
        hold = out_data;
        repeat (3) begin
            cycle();
            chk("bp_hold", out_data, hold);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1;
        nacc = 0;
        for (int j = 0; j < 4; j++) begin
            d2 = (j == 0) ? d1 : rnd128();
            in_valid = 1; in_data = d2; in_last = (j == 3);
            cycle();
            if (m_acc) nacc++;
            chk("bp_burst_data", out_data,
                d2 ^ ref_aes({iv[127:32], iv[31:0] + 32'(j + 1)}, k));
        end
        chk("bp_burst_count", nacc, 4);
        drain();

        k = rnd128(); iv = rnd128(); iv[31:0] = 32'h100;
        load(k, iv);
        send(rnd128(), 0);
        cfg_valid = 1; cfg_key = ~k; cfg_iv = rnd128();
        repeat (2) cycle();
        cfg_valid = 0;
        d1 = rnd128();
        send(d1, 1);
        chk("cfg_in_run_ignored", out_data, d1 ^ ref_aes({iv[127:32], 32'h101}, k));
        drain();

        load(rnd128(), rnd128());
        out_ready = 0;
        send(rnd128(), 0);
        chk("rst_mid_pre_valid", out_valid, 1'b1);
        #2;
        rst_n = 0;
        #1;
        m_reset();
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_data", out_data, 128'h0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
        in_valid = 1; in_data = rnd128(); out_ready = 1;
        repeat (3) cycle();
        in_valid = 0;
        chk("rst_mid_no_emit", out_valid, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_key = rnd128();
            cfg_iv = rnd128();
            if ($urandom_range(0, 2) == 0) cfg_iv[31:0] = 32'hffff_ffff - $urandom_range(0, 3);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = rnd128();
            in_last = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        cfg_valid = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
